cp0_exc: RTL and testbench

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_exc_if.sv | 32 +++
 rtl/cp0_timer.sv | 56 +++++
 rtl/cp0_exc.sv | 132 +++++++++++++
 tb/tb_cp0_exc.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants, register field layouts and read-format helpers.
// Optional timer build: define CP0_TIMER_EN.
package cp0_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // ip_hw holds IP[7:2] as sampled from int_in, ip_sw holds IP[1:0]
  typedef struct packed {
    logic       bd;
    logic [5:0] ip_hw;
    logic [1:0] ip_sw;
    logic [4:0] exccode;
  } cause_t;

  function automatic logic [XLEN-1:0] status_word(input status_t s);
    return {16'd0, s.im, 6'd0, s.exl, s.ie};
  endfunction

  function automatic logic [XLEN-1:0] cause_word(input logic bd, input logic [7:0] ip,
                                                 input logic [4:0] code);
    return {bd, 15'd0, ip, 1'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_if.sv
// MEM-stage to CP0 connection: exception flags, mtc0/mfc0 ports, interrupts and redirect.
interface cp0_exc_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic        mem_syscall;
  logic        mem_unknown;
  logic        mem_ovf;
  logic        mem_eret;
  logic        mem_cp0_we;
  logic [4:0]  mem_cp0_addr;
  logic [31:0] mem_cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [5:0]  int_in;
  logic        exc_flush;
  logic [31:0] exc_pc;
  logic [31:0] epc;
  logic        exl;

  modport master (
    output mem_valid, mem_pc, mem_bd, mem_syscall, mem_unknown, mem_ovf, mem_eret,
           mem_cp0_we, mem_cp0_addr, mem_cp0_wdata, cp0_raddr, int_in,
    input  cp0_rdata, exc_flush, exc_pc, epc, exl
  );

  modport slave (
    input  mem_valid, mem_pc, mem_bd, mem_syscall, mem_unknown, mem_ovf, mem_eret,
           mem_cp0_we, mem_cp0_addr, mem_cp0_wdata, cp0_raddr, int_in,
    output cp0_rdata, exc_flush, exc_pc, epc, exl
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky match flag; only built when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            wr_count_i,
  input  logic            wr_compare_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] count_o,
  output logic [XLEN-1:0] compare_o,
  output logic            pending_o
);

  logic [XLEN-1:0] count_q, count_d, compare_q, compare_d, count_inc;
  logic            pending_q, pending_d;

  assign count_inc = count_q + XLEN'(1);

  // Count write beats the increment; a Compare write always clears the flag
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    pending_d = pending_q;
    if (en_i) begin
      if (wr_count_i) begin
        count_d = wdata_i;
      end else begin
        count_d = count_inc;
        if (count_inc == compare_q) pending_d = 1'b1;
      end
      if (wr_compare_i) begin
        compare_d = wdata_i;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception unit: Status/Cause/EPC, exception priority and pipeline redirect.
// Define CP0_TIMER_EN to add the Count/Compare timer on IP[7].
module cp0_exc
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  cp0_exc_if.slave bus
);

  logic            run_q;
  status_t         status_q, status_d;
  cause_t          cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic [XLEN-1:0] count_v, compare_v;
  logic            timer_pend;
  logic [7:0]      ip_c;
  logic            int_pend, exc_take, eret_take, wr_en;
  logic [4:0]      exc_code;

  assign wr_en = run_q & bus.mem_valid & bus.mem_cp0_we & ~exc_take & ~eret_take;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (run_q),
    .wr_count_i   (wr_en && (bus.mem_cp0_addr == CP0_COUNT)),
    .wr_compare_i (wr_en && (bus.mem_cp0_addr == CP0_COMPARE)),
    .wdata_i      (bus.mem_cp0_wdata),
    .count_o      (count_v),
    .compare_o    (compare_v),
    .pending_o    (timer_pend)
  );
`else
  assign count_v    = '0;
  assign compare_v  = '0;
  assign timer_pend = 1'b0;
`endif

  assign ip_c     = {cause_q.ip_hw[5] | timer_pend, cause_q.ip_hw[4:0], cause_q.ip_sw};
  assign int_pend = status_q.ie & ~status_q.exl & (|(ip_c & status_q.im));

  // Priority: interrupt > reserved instruction > syscall > overflow > eret
  always_comb begin
    exc_take = 1'b0;
    exc_code = EXC_INT;
    if (run_q && bus.mem_valid) begin
      if (int_pend) begin
        exc_take = 1'b1;
        exc_code = EXC_INT;
      end else if (bus.mem_unknown) begin
        exc_take = 1'b1;
        exc_code = EXC_RI;
      end else if (bus.mem_syscall) begin
        exc_take = 1'b1;
        exc_code = EXC_SYS;
      end else if (bus.mem_ovf) begin
        exc_take = 1'b1;
        exc_code = EXC_OV;
      end
    end
  end

  assign eret_take     = run_q & bus.mem_valid & bus.mem_eret & ~exc_take;
  assign bus.exc_flush = exc_take | eret_take;
  assign bus.exc_pc    = exc_take ? EXC_VECTOR : epc_q;
  assign bus.epc       = epc_q;
  assign bus.exl       = status_q.exl;

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_raddr)
      CP0_COUNT:   bus.cp0_rdata = count_v;
      CP0_COMPARE: bus.cp0_rdata = compare_v;
      CP0_STATUS:  bus.cp0_rdata = status_word(status_q);
      CP0_CAUSE:   bus.cp0_rdata = cause_word(cause_q.bd, ip_c, cause_q.exccode);
      CP0_EPC:     bus.cp0_rdata = epc_q;
      default:     bus.cp0_rdata = '0;
    endcase
  end

  // Exception/eret take precedence over, and suppress, a same-cycle mtc0
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (run_q) begin
      cause_d.ip_hw = bus.int_in;
      if (exc_take) begin
        status_d.exl    = 1'b1;
        cause_d.exccode = exc_code;
        if (!status_q.exl) begin
          epc_d      = bus.mem_bd ? bus.mem_pc - XLEN'(4) : bus.mem_pc;
          cause_d.bd = bus.mem_bd;
        end
      end else if (eret_take) begin
        status_d.exl = 1'b0;
      end else if (wr_en) begin
        case (bus.mem_cp0_addr)
          CP0_STATUS: begin
            status_d.im  = bus.mem_cp0_wdata[15:8];
            status_d.exl = bus.mem_cp0_wdata[1];
            status_d.ie  = bus.mem_cp0_wdata[0];
          end
          CP0_CAUSE: cause_d.ip_sw = bus.mem_cp0_wdata[9:8];
          CP0_EPC:   epc_d = bus.mem_cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  // run_q holds off all updates on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      run_q    <= 1'b1;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed table, timer/reset sequences and random traffic
// against a register-array reference model. Timer checks are built when CP0_TIMER_EN is defined.
module tb_cp0_exc;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_exc_if bus();
  cp0_exc #(.EXC_VECTOR(32'h0000_0180)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd, sys, unk, ovf, eret, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  irq;
  } in_t;

  typedef struct {
    in_t         i;
    logic        ef;
    logic [31:0] xpc, rd;
    logic        xexl;
    logic [31:0] xepc;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: CP0 register file as plain words indexed by address
  logic [31:0] mreg [0:31];
  logic [5:0]  m_hw;
  logic        m_tp, m_run;

  function automatic in_t mk(logic valid, logic [31:0] pc, logic bd, logic sys, logic unk,
                             logic ovf, logic eret, logic we, logic [4:0] waddr,
                             logic [31:0] wdata, logic [4:0] raddr, logic [5:0] irq);
    in_t r;
    r.valid = valid; r.pc = pc; r.bd = bd; r.sys = sys; r.unk = unk; r.ovf = ovf;
    r.eret = eret; r.we = we; r.waddr = waddr; r.wdata = wdata; r.raddr = raddr; r.irq = irq;
    return r;
  endfunction

  function automatic in_t idl(logic [4:0] raddr, logic [5:0] irq);
    return mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, raddr, irq);
  endfunction

  function automatic vec_t vv(in_t i, logic ef, logic [31:0] xpc, logic [31:0] rd,
                              logic xexl, logic [31:0] xepc);
    vec_t r;
    r.i = i; r.ef = ef; r.xpc = xpc; r.rd = rd; r.xexl = xexl; r.xepc = xepc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9, 5'd11: begin
`ifdef CP0_TIMER_EN
        return mreg[a];
`else
        return 32'd0;
`endif
      end
      5'd12: return mreg[12];
      5'd13: return mreg[13] | (32'({m_hw[5] | m_tp, m_hw[4:0]}) << 10);
      5'd14: return mreg[14];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wmask(input logic [4:0] a);
    case (a)
`ifdef CP0_TIMER_EN
      5'd9, 5'd11: return 32'hFFFF_FFFF;
`endif
      5'd12: return 32'h0000_FF03;
      5'd13: return 32'h0000_0300;
      5'd14: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_decide(input in_t i, output logic fl, output logic ex, output logic [4:0] code);
    logic [31:0] st, cz;
    logic [7:0] ipv, imv;
    fl = 1'b0; ex = 1'b0; code = 5'd0;
    if (m_run && i.valid) begin
      st = mreg[12];
      cz = m_read(5'd13);
      ipv = cz[15:8];
      imv = st[15:8];
      if (st[0] && !st[1] && ((ipv & imv) != 8'd0)) begin ex = 1'b1; code = 5'd0; end
      else if (i.unk) begin ex = 1'b1; code = 5'd10; end
      else if (i.sys) begin ex = 1'b1; code = 5'd8; end
      else if (i.ovf) begin ex = 1'b1; code = 5'd12; end
      fl = ex | i.eret;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
    m_hw = 6'd0; m_tp = 1'b0; m_run = 1'b0;
  endtask

  task automatic model_step(input in_t i);
    logic fl, ex, wr;
    logic [4:0] code;
    logic [31:0] old_cmp, m;
    if (!m_run) begin
      m_run = 1'b1;
      return;
    end
    m_decide(i, fl, ex, code);
    wr = i.valid && i.we && !fl;
    old_cmp = mreg[11];
    if (ex) begin
      if (!mreg[12][1]) begin
        mreg[14] = i.bd ? i.pc - 32'd4 : i.pc;
        mreg[13][31] = i.bd;
      end
      mreg[13][6:2] = code;
      mreg[12][1] = 1'b1;
    end else if (fl) begin
      mreg[12][1] = 1'b0;
    end else if (wr) begin
      m = m_wmask(i.waddr);
      mreg[i.waddr] = (mreg[i.waddr] & ~m) | (i.wdata & m);
    end
`ifdef CP0_TIMER_EN
    if (!(wr && i.waddr == 5'd9)) begin
      mreg[9] = mreg[9] + 32'd1;
      if (mreg[9] == old_cmp) m_tp = 1'b1;
    end
    if (wr && i.waddr == 5'd11) m_tp = 1'b0;
`endif
    m_hw = i.irq;
  endtask

  task automatic drive(input in_t i);
    bus.mem_valid = i.valid; bus.mem_pc = i.pc; bus.mem_bd = i.bd;
    bus.mem_syscall = i.sys; bus.mem_unknown = i.unk; bus.mem_ovf = i.ovf;
    bus.mem_eret = i.eret; bus.mem_cp0_we = i.we; bus.mem_cp0_addr = i.waddr;
    bus.mem_cp0_wdata = i.wdata; bus.cp0_raddr = i.raddr; bus.int_in = i.irq;
  endtask

  task automatic drive_and_check(input in_t i);
    logic fl, ex;
    logic [4:0] code;
    @(negedge clk);
    drive(i);
    #1;
    m_decide(i, fl, ex, code);
    chk("model_flush", 32'(bus.exc_flush), 32'(fl));
    if (fl) chk("model_exc_pc", bus.exc_pc, ex ? 32'h0000_0180 : mreg[14]);
    chk("model_rdata", bus.cp0_rdata, m_read(i.raddr));
    chk("model_epc", bus.epc, mreg[14]);
    chk("model_exl", 32'(bus.exl), 32'(mreg[12][1]));
  endtask

  task automatic finish_cycle(input in_t i);
    @(posedge clk);
    model_step(i);
  endtask

  task automatic tick(input in_t i);
    drive_and_check(i);
    finish_cycle(i);
  endtask

  // Async reset mid-cycle with a syscall+mtc0 pending, then the inert first edge
  task automatic do_reset();
    in_t busy;
    logic [4:0] alist [5];
    alist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    busy = mk(1'b1, 32'h0040_0500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14,
              32'hFFFF_FFFF, 5'd12, 6'h3F);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(busy);
    #1;
    model_reset();
    chk("rst_flush", 32'(bus.exc_flush), 32'd0);
    chk("rst_exl", 32'(bus.exl), 32'd0);
    chk("rst_epc", bus.epc, 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus.cp0_raddr = alist[k];
      #1;
      chk("rst_rdata", bus.cp0_rdata, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(busy);
    #1;
    chk("first_edge_flush", 32'(bus.exc_flush), 32'd0);
    finish_cycle(busy);
  endtask

  function automatic in_t rand_in();
    in_t r;
    logic [4:0] alist [5];
    int unsigned k;
    alist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    r.valid = ($urandom_range(0, 3) != 0);
    r.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    r.bd    = ($urandom_range(0, 3) == 0);
    r.sys   = ($urandom_range(0, 7) == 0);
    r.unk   = ($urandom_range(0, 9) == 0);
    r.ovf   = ($urandom_range(0, 7) == 0);
    r.eret  = ($urandom_range(0, 5) == 0);
    r.we    = ($urandom_range(0, 2) == 0);
    k = $urandom_range(0, 5);
    r.waddr = (k == 5) ? 5'($urandom) : alist[k];
    r.wdata = (r.waddr == 5'd11) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    k = $urandom_range(0, 4);
    r.raddr = alist[k];
    r.irq   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [20];
    tab[0]  = vv(idl(5'd12, 6'd0), 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tab[1]  = vv(mk(1'b1, 32'h0040_0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 6'd0),
                 1'b1, 32'h0000_0180, 32'h0, 1'b0, 32'h0);
    tab[2]  = vv(idl(5'd13, 6'd0), 1'b0, 32'h0, 32'h0000_0020, 1'b1, 32'h0040_0010);
    tab[3]  = vv(mk(1'b1, 32'h0040_0014, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 5'd12, 6'd0),
                 1'b0, 32'h0, 32'h0000_0002, 1'b1, 32'h0040_0010);
    tab[4]  = vv(mk(1'b1, 32'h0040_0024, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 6'd0),
                 1'b1, 32'h0000_0180, 32'h0, 1'b0, 32'h0040_0010);
    tab[5]  = vv(idl(5'd13, 6'd0), 1'b0, 32'h0, 32'h8000_0030, 1'b1, 32'h0040_0020);
    tab[6]  = vv(mk(1'b1, 32'h0000_0184, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h0040_0100, 5'd14, 6'd0),
                 1'b0, 32'h0, 32'h0040_0020, 1'b1, 32'h0040_0020);
    tab[7]  = vv(mk(1'b1, 32'h0000_0188, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 32'hDEAD_BEEF, 5'd14, 6'd0),
                 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b1, 32'h0040_0100);
    tab[8]  = vv(idl(5'd14, 6'd0), 1'b0, 32'h0, 32'h0040_0100, 1'b0, 32'h0040_0100);
    tab[9]  = vv(mk(1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 5'd12, 6'b000001),
                 1'b0, 32'h0, 32'h0, 1'b0, 32'h0040_0100);
    tab[10] = vv(mk(1'b1, 32'h0040_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 6'b000001),
                 1'b1, 32'h0000_0180, 32'h8000_0430, 1'b0, 32'h0040_0100);
    tab[11] = vv(idl(5'd13, 6'b000001), 1'b0, 32'h0, 32'h0000_0400, 1'b1, 32'h0040_0200);
    tab[12] = vv(mk(1'b1, 32'h0000_0180, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 6'b000001),
                 1'b0, 32'h0, 32'h0000_0403, 1'b1, 32'h0040_0200);
    tab[13] = vv(mk(1'b1, 32'h0040_0300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 6'b000001),
                 1'b1, 32'h0000_0180, 32'h0000_0400, 1'b1, 32'h0040_0200);
    tab[14] = vv(idl(5'd13, 6'b000001), 1'b0, 32'h0, 32'h0000_0428, 1'b1, 32'h0040_0200);
    tab[15] = vv(mk(1'b1, 32'h0040_0304, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 5'd14, 6'b000001),
                 1'b1, 32'h0000_0180, 32'h0040_0200, 1'b1, 32'h0040_0200);
    tab[16] = vv(idl(5'd13, 6'd0), 1'b0, 32'h0, 32'h0000_0420, 1'b1, 32'h0040_0200);
    tab[17] = vv(mk(1'b0, 32'h0040_0308, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 6'd0),
                 1'b0, 32'h0, 32'h0000_0403, 1'b1, 32'h0040_0200);
    tab[18] = vv(mk(1'b1, 32'h0000_0190, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0),
                 1'b0, 32'h0, 32'h0000_0020, 1'b1, 32'h0040_0200);
    tab[19] = vv(idl(5'd13, 6'd0), 1'b0, 32'h0, 32'h0000_0320, 1'b1, 32'h0040_0200);

    do_reset();

    for (int r = 0; r < 20; r++) begin
      drive_and_check(tab[r].i);
      chk($sformatf("tab%0d_flush", r), 32'(bus.exc_flush), 32'(tab[r].ef));
      if (tab[r].ef) chk($sformatf("tab%0d_exc_pc", r), bus.exc_pc, tab[r].xpc);
      chk($sformatf("tab%0d_rdata", r), bus.cp0_rdata, tab[r].rd);
      chk($sformatf("tab%0d_exl", r), 32'(bus.exl), 32'(tab[r].xexl));
      chk($sformatf("tab%0d_epc", r), bus.epc, tab[r].xepc);
      finish_cycle(tab[r].i);
    end

`ifdef CP0_TIMER_EN
    // Compare=5, Count=0, then IP[7] rises five cycles later and sticks until Compare is rewritten
    do_reset();
    tick(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd5, 5'd11, 6'd0));
    tick(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 5'd9, 6'd0));
    for (int k = 0; k < 5; k++) begin
      drive_and_check(idl(5'd9, 6'd0));
      chk("tmr_count", bus.cp0_rdata, 32'(k));
      finish_cycle(idl(5'd9, 6'd0));
    end
    drive_and_check(idl(5'd13, 6'd0));
    chk("tmr_ip7_set", bus.cp0_rdata, 32'h0000_8000);
    finish_cycle(idl(5'd13, 6'd0));
    drive_and_check(idl(5'd9, 6'd0));
    chk("tmr_count6", bus.cp0_rdata, 32'd6);
    finish_cycle(idl(5'd9, 6'd0));
    drive_and_check(idl(5'd13, 6'd0));
    chk("tmr_ip7_held", bus.cp0_rdata, 32'h0000_8000);
    finish_cycle(idl(5'd13, 6'd0));
    tick(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd100, 5'd13, 6'd0));
    drive_and_check(idl(5'd13, 6'd0));
    chk("tmr_ip7_clr", bus.cp0_rdata, 32'h0);
    finish_cycle(idl(5'd13, 6'd0));
`else
    // Count/Compare are absent: writes vanish and reads return 0
    tick(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1234, 5'd9, 6'd0));
    drive_and_check(idl(5'd9, 6'd0));
    chk("notmr_count", bus.cp0_rdata, 32'h0);
    finish_cycle(idl(5'd9, 6'd0));
`endif

    for (int r = 0; r < 600; r++) tick(rand_in());
    do_reset();
    for (int r = 0; r < 200; r++) tick(rand_in());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
